// File: rtl/bofs_iterator.sv
// Block-offset iterator: walks block-aligned origins of an index space, innermost dim VDIM-1.
// First beat one cycle after command accept; one beat per cycle, held stable while i_ack is low.
package TauCfg;
    localparam int WORK_BW = 16;
    localparam int VDIM    = 2;
endpackage

module bofs_iterator #(
    parameter int WBW  = TauCfg::WORK_BW,
    parameter int VDIM = TauCfg::VDIM,
    parameter int SBW  = $clog2(WBW)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_rdy,
    output logic                      o_cmd_ack,
    input  logic [VDIM-1:0][WBW-1:0]  i_bend,
    input  logic [VDIM-1:0][SBW-1:0]  i_bshape,
    output logic                      o_rdy,
    input  logic                      i_ack,
    output logic [VDIM-1:0][WBW-1:0]  o_bofs,
    output logic [VDIM-1:0][WBW-1:0]  o_bboundary,
    output logic                      o_last
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                    state_q, state_d;
    logic [VDIM-1:0][WBW-1:0]  bofs_q, bofs_d;
    logic [VDIM-1:0][WBW-1:0]  bend_q, bend_d;
    logic [VDIM-1:0][SBW-1:0]  shape_q, shape_d;
    logic                      last_q, last_d;

    logic [VDIM-1:0][WBW:0]    nxt;
    logic [VDIM-1:0]           wrap;
    logic [VDIM-1:0]           step;
    logic                      empty_cmd;

    // Sum is kept one bit wider so a carry out of WBW bits counts as a wrap.
    function automatic logic [WBW:0] bump(input logic [WBW-1:0] ofs, input logic [SBW-1:0] shp);
        return {1'b0, ofs} + ((WBW+1)'(1) << shp);
    endfunction

    function automatic logic all_wrap(input logic [VDIM-1:0][WBW-1:0] ofs,
                                      input logic [VDIM-1:0][SBW-1:0] shp,
                                      input logic [VDIM-1:0][WBW-1:0] bnd);
        logic r;
        r = 1'b1;
        for (int j = 0; j < VDIM; j++) begin
            r = r & (bump(ofs[j], shp[j]) >= {1'b0, bnd[j]});
        end
        return r;
    endfunction

    always_comb begin
        empty_cmd = 1'b0;
        for (int j = 0; j < VDIM; j++) begin
            nxt[j]    = bump(bofs_q[j], shape_q[j]);
            wrap[j]   = nxt[j] >= {1'b0, bend_q[j]};
            empty_cmd = empty_cmd | (i_bend[j] == '0);
        end
        step[VDIM-1] = 1'b1;
        for (int j = VDIM - 2; j >= 0; j--) begin
            step[j] = step[j+1] & wrap[j+1];
        end
    end

    always_comb begin
        state_d   = state_q;
        bofs_d    = bofs_q;
        bend_d    = bend_q;
        shape_d   = shape_q;
        last_d    = last_q;
        o_cmd_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_cmd_ack = i_cmd_rdy;
                if (i_cmd_rdy) begin
                    bend_d  = i_bend;
                    shape_d = i_bshape;
                    if (!empty_cmd) begin
                        bofs_d  = '0;
                        last_d  = all_wrap('0, i_bshape, i_bend);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (i_ack) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        for (int j = 0; j < VDIM; j++) begin
                            if (step[j]) begin
                                bofs_d[j] = wrap[j] ? '0 : nxt[j][WBW-1:0];
                            end
                        end
                        last_d = all_wrap(bofs_d, shape_q, bend_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            bofs_q  <= '0;
            bend_q  <= '0;
            shape_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bofs_q  <= bofs_d;
            bend_q  <= bend_d;
            shape_q <= shape_d;
            last_q  <= last_d;
        end
    end

    assign o_rdy       = (state_q == S_RUN);
    assign o_bofs      = bofs_q;
    assign o_bboundary = bend_q;
    assign o_last      = last_q;

endmodule

// File: tb/tb_bofs_iterator.sv
// Bench for bofs_iterator: directed cases plus random commands against a nested-loop origin model.
module tb_bofs_iterator;
    localparam int WBW  = TauCfg::WORK_BW;
    localparam int VDIM = 2;
    localparam int SBW  = $clog2(WBW);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      cmd_rdy = 1'b0;
    logic                      cmd_ack;
    logic                      rdy;
    logic                      ack = 1'b0;
    logic                      last;
    logic [VDIM-1:0][WBW-1:0]  bend = '0;
    logic [VDIM-1:0][SBW-1:0]  bshape = '0;
    logic [VDIM-1:0][WBW-1:0]  bofs;
    logic [VDIM-1:0][WBW-1:0]  bbound;

    int n_chk  = 0;
    int n_pass = 0;

    // Each entry: {last, bofs[0], bofs[1]}
    logic [2*WBW:0]   exp_q[$];
    logic [2*WBW-1:0] exp_bnd;
    logic [2*WBW-1:0] last_bofs;
    logic [6:0]       ack_pat = 7'b1001101;

    bofs_iterator #(.WBW(WBW), .VDIM(VDIM), .SBW(SBW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_rdy   (cmd_rdy),
        .o_cmd_ack   (cmd_ack),
        .i_bend      (bend),
        .i_bshape    (bshape),
        .o_rdy       (rdy),
        .i_ack       (ack),
        .o_bofs      (bofs),
        .o_bboundary (bbound),
        .o_last      (last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic build_model(input int b0, input int b1, input int s0, input int s1);
        logic [2*WBW:0] e;
        exp_q.delete();
        exp_bnd = {WBW'(b0), WBW'(b1)};
        if (b0 > 0 && b1 > 0) begin
            for (int x = 0; x < b0; x += (1 << s0))
                for (int y = 0; y < b1; y += (1 << s1))
                    exp_q.push_back({1'b0, WBW'(x), WBW'(y)});
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_back();
            e[2*WBW] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic issue(input int b0, input int b1, input int s0, input int s1, input bit hold);
        bend[0]   = WBW'(b0);
        bend[1]   = WBW'(b1);
        bshape[0] = SBW'(s0);
        bshape[1] = SBW'(s1);
        cmd_rdy   = 1'b1;
        build_model(b0, b1, s0, s1);
        @(negedge clk);
        check("cmd_ack", cmd_ack, 1);
        check("idle_rdy", rdy, 0);
        @(posedge clk); #1;
        if (!hold) cmd_rdy = 1'b0;
    endtask

    // mode 0: ack always, 1: fixed pattern, 2: random
    task automatic drain(input int mode);
        int  cyc = 0;
        int  n = 0;
        bit  had = (exp_q.size() > 0);
        logic a;
        while (exp_q.size() > 0 && cyc < 4000) begin
            case (mode)
                0:       a = 1'b1;
                1:       a = ack_pat[6 - (n % 7)];
                default: a = 1'($urandom_range(0, 1));
            endcase
            ack = a;
            @(negedge clk);
            check("rdy", rdy, 1);
            check("bofs", {bofs[0], bofs[1]}, exp_q[0][2*WBW-1:0]);
            check("last", last, exp_q[0][2*WBW]);
            check("bbound", {bbound[0], bbound[1]}, exp_bnd);
            check("ack_run", cmd_ack, 0);
            @(posedge clk); #1;
            if (a) begin
                last_bofs = exp_q[0][2*WBW-1:0];
                void'(exp_q.pop_front());
            end
            cyc++;
            n++;
        end
        if (exp_q.size() != 0) check("timeout", exp_q.size(), 0);
        ack = 1'b0;
        @(negedge clk);
        check("rdy_drop", rdy, 0);
        check("ack_idle", cmd_ack, cmd_rdy);
        if (had) check("bofs_hold", {bofs[0], bofs[1]}, last_bofs);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, s0, s1;
        #3;
        check("rst_rdy", rdy, 0);
        check("rst_last", last, 0);
        check("rst_bofs", {bofs[0], bofs[1]}, 0);
        check("rst_bbound", {bbound[0], bbound[1]}, 0);
        check("rst_cmd_ack", cmd_ack, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(4, 6, 1, 2, 0);
        drain(0);
        issue(4, 6, 1, 2, 0);
        drain(1);

        issue(0, 5, 0, 0, 0);
        issue(3, 3, 0, 0, 0);
        drain(0);

        issue(1, (1 << WBW) - 1, 0, WBW - 1, 0);
        drain(0);

        // Command held during RUN; second copy accepted the cycle after the last ack.
        issue(4, 6, 1, 2, 1);
        drain(0);
        cmd_rdy = 1'b0;
        build_model(4, 6, 1, 2);
        drain(0);

        issue(8, 8, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            ack = 1'b1;
            @(negedge clk);
            check("pre_rst_bofs", {bofs[0], bofs[1]}, exp_q[0][2*WBW-1:0]);
            @(posedge clk); #1;
            void'(exp_q.pop_front());
        end
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", rdy, 0);
        check("mid_rst_bofs", {bofs[0], bofs[1]}, 0);
        check("mid_rst_last", last, 0);
        check("mid_rst_bbound", {bbound[0], bbound[1]}, 0);
        #2;
        rst = 1'b0;
        ack = 1'b0;
        @(posedge clk); #1;
        issue(8, 8, 1, 1, 0);
        drain(2);

        for (int k = 0; k < 25; k++) begin
            if (k % 5 == 4) begin
                b0 = int'($urandom_range(1, (1 << WBW) - 1));
                b1 = int'($urandom_range(1, (1 << WBW) - 1));
                s0 = int'($urandom_range(12, WBW - 1));
                s1 = int'($urandom_range(12, WBW - 1));
            end else begin
                b0 = int'($urandom_range(0, 20));
                b1 = int'($urandom_range(1, 20));
                s0 = int'($urandom_range(0, 3));
                s1 = int'($urandom_range(0, 3));
            end
            issue(b0, b1, s0, s1, 0);
            drain(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bofs_iterator.md
# bofs_iterator

Block-offset iterator: the producer that feeds the block-offset expander in the TileAccumUnit. Accepts one command describing an index-space boundary and a power-of-two block shape per dimension. Walks every block-aligned origin in that space, row-major with dimension VDIM-1 innermost. Emits one (bofs, bboundary) beat per cycle over a rdy/ack handshake. Because every emitted offset is aligned to its block, the expander can OR per-lane sub-offsets into the low bits.

## Interface
- WBW, default TauCfg::WORK_BW: width of one offset/boundary coordinate.
- VDIM, default TauCfg::VDIM: number of dimensions.
- SBW, default $clog2(WBW): width of a block-shape log2 field.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset; one clock, reset is asynchronous and active-high.
- i_cmd_rdy  in  1  command valid.
- o_cmd_ack  out  1  command accepted; high only in IDLE, equals i_cmd_rdy there.
- i_bend  in  [WBW-1:0] x VDIM  exclusive upper boundary per dimension.
- i_bshape  in  [SBW-1:0] x VDIM  log2 of block size per dimension.
- o_rdy  out  1  output beat valid.
- i_ack  in  1  downstream accepts beat; meaningful only while o_rdy.
- o_bofs  out  [WBW-1:0] x VDIM  current block origin.
- o_bboundary  out  [WBW-1:0] x VDIM  latched i_bend, constant for the whole command.
- o_last  out  1  current beat is the final beat of the command.

## Operation
- States: IDLE, RUN.
- IDLE: o_rdy=0, o_cmd_ack=i_cmd_rdy. On i_cmd_rdy, latch i_bend into o_bboundary and i_bshape into an internal shape register.
  - Empty command (any i_bend[j]==0): acknowledged, no beats emitted, remain IDLE.
  - Otherwise: o_bofs set to all zero, o_last computed, enter RUN.
- RUN: o_rdy=1, o_cmd_ack=0; i_cmd_rdy is ignored.
- Advance on o_rdy && i_ack:
  - Per dimension, compute nxt[j] = o_bofs[j] + (1<<shape[j]) in WBW+1 bits, so there is no wrap-around.
  - Dimension j wraps when nxt[j] >= bend[j], or when nxt[j] carries out of WBW bits.
  - Innermost dimension VDIM-1 always steps. Dimension j steps only when all dimensions j+1..VDIM-1 wrap.
  - A wrapping dimension that steps loads 0. A non-wrapping dimension that steps loads nxt[j]. A dimension that does not step holds.
- o_last=1 iff every dimension would wrap on the next advance. It is registered together with o_bofs.
- Handshake on a beat with o_last=1: return to IDLE. o_bofs holds its final value; o_rdy drops the next cycle.
- No advance while i_ack=0: o_bofs, o_last and o_bboundary are held stable.
- Shape values with 1<<shape >= bend yield exactly one origin (0) for that dimension.

## Timing
- Reset values: state IDLE; o_rdy=0, o_last=0, o_bofs all 0, o_bboundary all 0, shape register 0. o_cmd_ack is combinational and therefore 0 unless i_cmd_rdy is high.
- Command accepted at edge t → o_rdy=1 with first beat valid after edge t.
- Sustained throughput: one beat per cycle while i_ack=1.
- Last beat acked at edge t → IDLE after t. The next command can be accepted at edge t+1, giving a minimum one-cycle bubble between commands.
- Reset asserted mid-RUN: outputs go to reset values immediately (asynchronous). The command in flight is discarded and no o_last is issued.
- Beat count per command = product over j of ceil(bend[j] / 2^shape[j]).

## Test plan
- VDIM=2, bend={4,6}, shape={1,2}, i_ack held high → beats (0,0),(0,4),(2,0),(2,4) on four consecutive cycles; o_last only on (2,4); o_bboundary={4,6} throughout; o_rdy=0 on the following cycle.
- Same command with i_ack toggled 1,0,0,1,1,0,1 → identical beat sequence; o_bofs and o_last stable during every i_ack=0 cycle.
- Empty command bend={0,5} → o_cmd_ack=1 for one cycle; o_rdy never rises; the next command is accepted on the next cycle.
- Overflow: bend[1]=2^WBW-1, shape[1]=WBW-1, bend[0]=1 → exactly two beats with o_bofs[1]=0 and 2^(WBW-1); o_last on the second beat; no third beat at offset 0.
- i_cmd_rdy held high during RUN → o_cmd_ack=0 until the last beat is acked; the second command's first beat appears two cycles after that ack.
- i_rst pulsed mid-command after two beats → o_rdy=0 and o_bofs=0 immediately; a fresh command restarts from origin 0.
